// File: rtl/nf10_drr_pkg.sv
// Shared widths, FSM encoding and the saturating adder for the DRR scheduler.
package nf10_drr_pkg;

  localparam int unsigned DRR_NUM_QUEUES    = 5;
  localparam int unsigned DRR_LEN_WIDTH     = 16;
  localparam int unsigned DRR_DEFICIT_WIDTH = 18;

  typedef enum logic {
    SCAN  = 1'b0,
    SERVE = 1'b1
  } drr_state_e;

  // Unsigned add of two values, clamped to 2^width-1 (width <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'(1) << width) - 33'(1);
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/nf10_drr_deficit_bank.sv
// Per-queue deficit counters: one indexed write port and one indexed read port.
module nf10_drr_deficit_bank
  import nf10_drr_pkg::*;
#(
  parameter int unsigned NUM_QUEUES    = DRR_NUM_QUEUES,
  parameter int unsigned DEFICIT_WIDTH = DRR_DEFICIT_WIDTH,
  parameter int unsigned IDX_WIDTH     = $clog2(NUM_QUEUES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IDX_WIDTH-1:0]     i_idx,
  input  logic                     i_we,
  input  logic [DEFICIT_WIDTH-1:0] i_wdata,
  output logic [DEFICIT_WIDTH-1:0] o_rdata_c
);

  logic [DEFICIT_WIDTH-1:0] r_deficit [NUM_QUEUES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
        r_deficit[i] <= '0;
      end
    end else if (i_we) begin
      r_deficit[i_idx] <= i_wdata;
    end
  end

  assign o_rdata_c = r_deficit[i_idx];

endmodule

// File: rtl/nf10_drr_scheduler.sv
// Deficit-round-robin packet scheduler: visits one queue per cycle and holds a
// one-hot grant for a whole packet until pkt_done.
module nf10_drr_scheduler
  import nf10_drr_pkg::*;
#(
  parameter int unsigned NUM_QUEUES     = DRR_NUM_QUEUES,
  parameter int unsigned LEN_WIDTH      = DRR_LEN_WIDTH,
  parameter int unsigned DEFICIT_WIDTH  = DRR_DEFICIT_WIDTH,
  parameter int unsigned QUEUE_ID_WIDTH = $clog2(NUM_QUEUES)
) (
  input  logic                                axi_aclk,
  input  logic                                axi_resetn,
  input  logic                                sched_en,
  input  logic [NUM_QUEUES-1:0]               queue_req,
  input  logic [NUM_QUEUES*LEN_WIDTH-1:0]     head_len,
  input  logic [NUM_QUEUES*DEFICIT_WIDTH-1:0] quantum,
  input  logic                                pkt_done,
  output logic [NUM_QUEUES-1:0]               grant,
  output logic [QUEUE_ID_WIDTH-1:0]           grant_queue,
  output logic                                grant_valid
);

  drr_state_e                r_state, w_state_nxt;
  logic [QUEUE_ID_WIDTH-1:0] r_cur_queue, w_cur_nxt, w_cur_inc;
  logic                      r_fresh, w_fresh_nxt;
  logic [NUM_QUEUES-1:0]     r_grant, w_grant_nxt;
  logic [QUEUE_ID_WIDTH-1:0] r_grant_queue, w_gq_nxt;
  logic                      r_grant_valid;

  logic [LEN_WIDTH-1:0]      w_head  [NUM_QUEUES];
  logic [DEFICIT_WIDTH-1:0]  w_quant [NUM_QUEUES];
  logic [DEFICIT_WIDTH-1:0]  w_def_rd, w_def_wdata, w_eff, w_eff_sat, w_head_ext;
  logic                      w_def_we;

  for (genvar g = 0; g < int'(NUM_QUEUES); g++) begin : g_unpack
    assign w_head[g]  = head_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign w_quant[g] = quantum[g*DEFICIT_WIDTH +: DEFICIT_WIDTH];
  end

  nf10_drr_deficit_bank #(
    .NUM_QUEUES   (NUM_QUEUES),
    .DEFICIT_WIDTH(DEFICIT_WIDTH),
    .IDX_WIDTH    (QUEUE_ID_WIDTH)
  ) u_bank (
    .clk      (axi_aclk),
    .rst_n    (axi_resetn),
    .i_idx    (r_cur_queue),
    .i_we     (w_def_we),
    .i_wdata  (w_def_wdata),
    .o_rdata_c(w_def_rd)
  );

  // A fresh visit tops the deficit up with the quantum; a revisit after a packet does not.
  assign w_eff_sat  = DEFICIT_WIDTH'(sat_add(32'(w_def_rd), 32'(w_quant[r_cur_queue]), DEFICIT_WIDTH));
  assign w_eff      = r_fresh ? w_eff_sat : w_def_rd;
  assign w_head_ext = DEFICIT_WIDTH'(w_head[r_cur_queue]);
  assign w_cur_inc  = (r_cur_queue == QUEUE_ID_WIDTH'(NUM_QUEUES - 1)) ?
                      '0 : r_cur_queue + QUEUE_ID_WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_queue;
    w_fresh_nxt = r_fresh;
    w_grant_nxt = r_grant;
    w_gq_nxt    = r_grant_queue;
    w_def_we    = 1'b0;
    w_def_wdata = w_eff;
    case (r_state)
      SCAN: begin
        if (sched_en) begin
          w_def_we = 1'b1;
          if (!queue_req[r_cur_queue]) begin
            w_def_wdata = '0;
            w_cur_nxt   = w_cur_inc;
            w_fresh_nxt = 1'b1;
          end else if (w_eff >= w_head_ext) begin
            w_def_wdata = w_eff - w_head_ext;
            w_grant_nxt = NUM_QUEUES'(1) << r_cur_queue;
            w_gq_nxt    = r_cur_queue;
            w_state_nxt = SERVE;
          end else begin
            w_cur_nxt   = w_cur_inc;
            w_fresh_nxt = 1'b1;
          end
        end
      end
      SERVE: begin
        // Stay on the same queue so it can spend any remaining deficit.
        if (pkt_done) begin
          w_grant_nxt = '0;
          w_fresh_nxt = 1'b0;
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state       <= SCAN;
      r_cur_queue   <= '0;
      r_fresh       <= 1'b1;
      r_grant       <= '0;
      r_grant_queue <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_queue   <= w_cur_nxt;
      r_fresh       <= w_fresh_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_queue <= w_gq_nxt;
      r_grant_valid <= |w_grant_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_queue = r_grant_queue;
  assign grant_valid = r_grant_valid;

endmodule
